// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Round-robin arbiter and write sequencer for a bank of NREG enable-gated
//   registers. Up to NREQ requesters share the bank's single write path.
//
//   For each write the arbiter does the following:
//     - picks one requester,
//     - latches that requester's address and data,
//     - strobes one active-low enable line for one cycle,
//     - pulses the winner's ack in the following cycle.
//
//   Every write takes exactly three cycles: IDLE -> STROBE -> ACK.
//
// Ports
//   clk         clock, all state changes on the rising edge
//   reset       synchronous, active-high reset
//   req         per-requester level request, held until ack
//   req_addr    requester i register address at [i*AW +: AW]
//   req_data    requester i write data at [i*WIDTH +: WIDTH]
//   ack         one-cycle completion pulse, one-hot or zero
//   addr_err    pulses with ack when the granted address was >= NREG
//   wr_data     data bus to every bank register input
//   wr_nEnable  active-low one-hot write enable, all ones when idle
//   busy        high while a write is in STROBE or ACK
//   grant_id    index of the current or most recent winner
module regbank_write_arbiter #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           ack,
    output logic                      addr_err,
    output logic [WIDTH-1:0]          wr_data,
    output logic [NREG-1:0]           wr_nEnable,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int GW = $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        ACK    = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [GW-1:0]     rr_ptr;
    logic              oor;

    logic [GW-1:0]     rr_ptr_d;
    logic              oor_d;
    logic [NREQ-1:0]   ack_d;
    logic              addr_err_d;
    logic [WIDTH-1:0]  wr_data_d;
    logic [NREG-1:0]   wr_nEnable_d;
    logic              busy_d;
    logic [GW-1:0]     grant_id_d;

    logic [GW-1:0]     winner;
    logic [AW-1:0]     sel_addr;
    logic [WIDTH-1:0]  sel_data;
    logic              sel_in_range;

    // The search starts one past the last winner, so the previous winner is
    // considered last. This gives strict rotation when several requesters
    // are waiting.
    function automatic logic [GW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [GW-1:0]   ptr);
        logic [GW-1:0] w;
        logic          found;
        int            idx;
        w     = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && r[idx]) begin
                w     = GW'(idx);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    assign winner       = rr_pick(req, rr_ptr);
    assign sel_addr     = req_addr[winner*AW +: AW];
    assign sel_data     = req_data[winner*WIDTH +: WIDTH];
    // The address is widened by one bit so that NREG == 2**AW still compares correctly.
    assign sel_in_range = ({1'b0, sel_addr} < (AW+1)'(NREG));

    // State register. Every output is registered here as well.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rr_ptr     <= GW'(NREQ - 1);
            oor        <= 1'b0;
            ack        <= '0;
            addr_err   <= 1'b0;
            wr_data    <= '0;
            wr_nEnable <= '1;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            state      <= next_state;
            rr_ptr     <= rr_ptr_d;
            oor        <= oor_d;
            ack        <= ack_d;
            addr_err   <= addr_err_d;
            wr_data    <= wr_data_d;
            wr_nEnable <= wr_nEnable_d;
            busy       <= busy_d;
            grant_id   <= grant_id_d;
        end
    end

    always_comb begin
        next_state = IDLE;
        case (state)
            IDLE:    next_state = (|req) ? STROBE : IDLE;
            STROBE:  next_state = ACK;
            ACK:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Computes the values the registered outputs will take in the next state.
    // wr_data holds its value outside the grant edge, so the bank continues to
    // see the last written value.
    always_comb begin
        rr_ptr_d     = rr_ptr;
        oor_d        = oor;
        ack_d        = '0;
        addr_err_d   = 1'b0;
        wr_data_d    = wr_data;
        wr_nEnable_d = '1;
        busy_d       = 1'b0;
        grant_id_d   = grant_id;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_id_d = winner;
                    wr_data_d  = sel_data;
                    oor_d      = !sel_in_range;
                    busy_d     = 1'b1;
                    if (sel_in_range) begin
                        wr_nEnable_d = ~(NREG'(1) << sel_addr);
                    end
                end
            end
            STROBE: begin
                ack_d      = NREQ'(1) << grant_id;
                addr_err_d = oor;
                busy_d     = 1'b1;
            end
            ACK: begin
                rr_ptr_d = grant_id;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter
//   Directed bench for regbank_write_arbiter.
//   It uses AW=4 so that out-of-range addresses such as 8 and 9 can be driven.
//   Single-request transactions come from a vector table. Multi-cycle
//   round-robin, reset-abort and latch behaviour are covered by hand-written
//   sequences.
//   A small register-bank model captures wr_data wherever wr_nEnable is low.
module tb_regbank_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int NREG  = 8;
    localparam int AW    = 4;

    logic                    clk;
    logic                    reset;
    logic [NREQ-1:0]         req;
    logic [NREQ*AW-1:0]      req_addr;
    logic [NREQ*WIDTH-1:0]   req_data;
    logic [NREQ-1:0]         ack;
    logic                    addr_err;
    logic [WIDTH-1:0]        wr_data;
    logic [NREG-1:0]         wr_nEnable;
    logic                    busy;
    logic [1:0]              grant_id;

    int tests;
    int failures;
    int violations;
    int order[$];
    logic [WIDTH-1:0] bank [NREG];

    typedef struct {
        logic [3:0]  req;
        logic [15:0] addr;
        logic [31:0] data;
        logic [1:0]  grant;
        logic [7:0]  n_en;
        logic [7:0]  wdata;
        logic        err;
    } vec_t;

    vec_t vecs [6];

    regbank_write_arbiter #(
        .WIDTH(WIDTH), .NREQ(NREQ), .NREG(NREG), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
        .req_data(req_data), .ack(ack), .addr_err(addr_err),
        .wr_data(wr_data), .wr_nEnable(wr_nEnable), .busy(busy),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            if (!wr_nEnable[i]) bank[i] <= wr_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [15:0] a,
                                 input logic [31:0] d);
        req      = r;
        req_addr = a;
        req_data = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs n cycles. On each cycle it records the order of acks, drops acked
    // requests as the requester protocol requires, and counts violations of
    // the one-hot invariants on ack and on the enable strobe.
    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            if (!$onehot0(ack)) violations++;
            if (!$onehot0(~wr_nEnable)) violations++;
            for (int j = 0; j < NREQ; j++) begin
                if (ack[j]) order.push_back(j);
            end
            req = req & ~ack;
        end
    endtask

    task automatic checkOrder(input string name, input int exp_order[$]);
        checkOutput({name, "_count"}, order.size(), exp_order.size());
        for (int k = 0; k < exp_order.size(); k++) begin
            checkOutput($sformatf("%s_%0d", name, k),
                        (k < order.size()) ? order[k] : 32'hFFFF, exp_order[k]);
        end
        order.delete();
    endtask

    initial begin
        tests      = 0;
        failures   = 0;
        violations = 0;
        reset      = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 32'h0);

        // Vectors run back to back. Each winner depends on the previous one
        // through the round-robin pointer, which starts at 3 after reset.
        vecs[0] = '{4'b0001, 16'h0005, 32'h000000A5, 2'd0, 8'hDF, 8'hA5, 1'b0};
        vecs[1] = '{4'b0100, 16'h0900, 32'h003C0000, 2'd2, 8'hFF, 8'h3C, 1'b1};
        vecs[2] = '{4'b1010, 16'h0030, 32'h11002200, 2'd3, 8'hFE, 8'h11, 1'b0};
        vecs[3] = '{4'b1010, 16'h2070, 32'h33007700, 2'd1, 8'h7F, 8'h77, 1'b0};
        vecs[4] = '{4'b0001, 16'h0008, 32'h0000005A, 2'd0, 8'hFF, 8'h5A, 1'b1};
        vecs[5] = '{4'b1111, 16'h4321, 32'h44434241, 2'd1, 8'hFB, 8'h42, 1'b0};

        tick();
        tick();
        checkOutput("rst_ack", ack, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_nen", wr_nEnable, 8'hFF);
        checkOutput("rst_data", wr_data, 0);
        checkOutput("rst_grant", grant_id, 0);
        checkOutput("rst_err", addr_err, 0);
        reset = 1'b0;

        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].req, vecs[v].addr, vecs[v].data);
            tick();
            checkOutput($sformatf("v%0d_strobe_nen", v), wr_nEnable, vecs[v].n_en);
            checkOutput($sformatf("v%0d_strobe_data", v), wr_data, vecs[v].wdata);
            checkOutput($sformatf("v%0d_strobe_grant", v), grant_id, vecs[v].grant);
            checkOutput($sformatf("v%0d_strobe_busy", v), busy, 1);
            checkOutput($sformatf("v%0d_strobe_ack", v), ack, 0);
            tick();
            checkOutput($sformatf("v%0d_ack", v), ack, 4'b0001 << vecs[v].grant);
            checkOutput($sformatf("v%0d_err", v), addr_err, vecs[v].err);
            checkOutput($sformatf("v%0d_ack_nen", v), wr_nEnable, 8'hFF);
            checkOutput($sformatf("v%0d_ack_data", v), wr_data, vecs[v].wdata);
            req = 4'b0000;
            tick();
            checkOutput($sformatf("v%0d_idle_ack", v), ack, 0);
            checkOutput($sformatf("v%0d_idle_busy", v), busy, 0);
            checkOutput($sformatf("v%0d_idle_err", v), addr_err, 0);
        end
        checkOutput("bank5", bank[5], 8'hA5);
        checkOutput("bank0", bank[0], 8'h11);
        checkOutput("bank7", bank[7], 8'h77);
        checkOutput("bank2", bank[2], 8'h42);

        // All four requesters held. Grants come in order 0..3 over 12 cycles.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        applyStimulus(4'b1111, 16'h3210, 32'hD3D2D1D0);
        runCycles(12);
        checkOrder("rr4", '{0, 1, 2, 3});
        checkOutput("rr4_end_busy", busy, 0);
        checkOutput("rr4_end_req", req, 0);

        // The pointer now sits at 3, so 0 beats 2. Then 1 joins during 0's ack
        // and overtakes 2.
        applyStimulus(4'b0101, 16'h0504, 32'h00550044);
        runCycles(2);
        req[1] = 1'b1;
        runCycles(7);
        checkOrder("rr3", '{0, 1, 2});
        checkOutput("inv_viol", violations, 0);

        // Reset lands at the end of STROBE. There is no ack, and the pointer
        // returns to 3, so requester 0 beats requester 3.
        applyStimulus(4'b0001, 16'h0003, 32'h00000099);
        tick();
        checkOutput("abort_strobe_busy", busy, 1);
        reset = 1'b1;
        tick();
        checkOutput("abort_ack", ack, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_nen", wr_nEnable, 8'hFF);
        reset = 1'b0;
        applyStimulus(4'b1001, 16'h6001, 32'h60000010);
        tick();
        checkOutput("post_rst_grant", grant_id, 0);
        checkOutput("post_rst_nen", wr_nEnable, 8'hFD);
        runCycles(5);
        checkOrder("post_rst", '{0, 3});

        // Address and data change during STROBE are ignored.
        applyStimulus(4'b0100, 16'h0400, 32'h00C30000);
        tick();
        req_addr = 16'h0100;
        req_data = 32'h00EE0000;
        tick();
        checkOutput("latch_ack", ack, 4'b0100);
        checkOutput("latch_bank4", bank[4], 8'hC3);
        checkOutput("latch_wdata", wr_data, 8'hC3);
        req = 4'b0000;
        tick();
        tick();
        checkOutput("stale_busy", busy, 0);
        checkOutput("stale_ack", ack, 0);

        // If the request stays high, the next grant follows a single idle cycle.
        applyStimulus(4'b0100, 16'h0200, 32'h005A0000);
        tick();
        tick();
        checkOutput("hold_ack", ack, 4'b0100);
        tick();
        checkOutput("hold_idle_busy", busy, 0);
        tick();
        checkOutput("hold_regrant_busy", busy, 1);
        checkOutput("hold_regrant_nen", wr_nEnable, 8'hFB);
        req = 4'b0000;
        tick();
        tick();
        tick();
        checkOutput("hold_final_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
